// File: rtl/bf16_pkg.sv
// Shared BF16 definitions for the accumulator slice.
// Field widths, special encodings, the accumulator FSM state type and the
// unpacked-operand view used by the align/add datapath.
package bf16_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;
  localparam int MANT_W = 11;   // hidden 1 + 7 fraction bits + 3 guard bits
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [15:0]      POS_ZERO = 16'h0000;
  localparam logic [15:0]      QNAN     = 16'h7FC0;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
    logic              inf;
  } bf16_unp_t;

  // Exponent 0 (zero or subnormal) flushes to a zero mantissa; exponent 0xFF
  // is treated as infinity regardless of the fraction.
  function automatic bf16_unp_t bf16_unpack(input logic [15:0] v);
    bf16_unp_t u;
    u.sign = v[15];
    u.exp  = v[14:FRAC_W];
    u.zero = (v[14:FRAC_W] == '0);
    u.inf  = (v[14:FRAC_W] == EXP_MAX);
    u.mant = u.zero ? '0 : {1'b1, v[FRAC_W-1:0], 3'b000};
    return u;
  endfunction

endpackage

// File: rtl/bf16_accumulator_align_add.sv
// Combinational align + add/subtract of two BF16 magnitudes.
// Ports: big_* is the operand with the larger exponent, small_* the other one;
// shamt right-shifts the small mantissa (11 or more clears it). Outputs the
// result sign, the pre-normalisation exponent, a 12-bit raw magnitude (bit 11
// is the carry out) and a flag for an exact-zero result.
module bf16_align_add
  import bf16_pkg::*;
(
  input  logic              big_sign,
  input  logic [EXP_W-1:0]  big_exp,
  input  logic [MANT_W-1:0] big_mant,
  input  logic              small_sign,
  input  logic [MANT_W-1:0] small_mant,
  input  logic [3:0]        shamt,
  output logic              sum_sign,
  output logic [EXP_W-1:0]  sum_exp,
  output logic [MANT_W:0]   sum_raw,
  output logic              sum_zero
);

  logic [MANT_W-1:0] small_al;

  // NOTE: every output gets a value on every path through this block, so no
  // latch is inferred; blocking '=' is correct in combinational logic.
  always_comb begin
    small_al = small_mant >> shamt;
    sum_exp  = big_exp;
    if (big_sign == small_sign) begin
      sum_sign = big_sign;
      sum_raw  = {1'b0, big_mant} + {1'b0, small_al};
    end else if (big_mant >= small_al) begin
      sum_sign = big_sign;
      sum_raw  = {1'b0, big_mant - small_al};
    end else begin
      // Only possible when exponents are equal and the small side is larger.
      sum_sign = small_sign;
      sum_raw  = {1'b0, small_al - big_mant};
    end
    sum_zero = (sum_raw == '0);
  end

endmodule

// File: rtl/bf16_accumulator.sv
// Sequential BF16 accumulator: sums a stream of BF16 operands into one BF16
// result using an IDLE/ALIGN/ADD/NORM/DONE state machine. Truncating
// rounding, subnormals flushed to zero, overflow saturates to Inf.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_last
// operand handshake; acc_valid/out_ready/acc_data result handshake.
// All outputs are registered.
module bf16_accumulator
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        acc_valid,
  input  logic        out_ready,
  output logic [15:0] acc_data
);

  state_e            state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       commit_val;
  logic              commit;
  logic              accept;

  // Operand latch and per-stage pipeline registers.
  logic [15:0]       op_q;
  logic              last_q;
  logic              big_sign_q, small_sign_q;
  logic [EXP_W-1:0]  big_exp_q;
  logic [MANT_W-1:0] big_mant_q, small_mant_q;
  logic [3:0]        shamt_q;
  logic              special_q;
  logic [15:0]       special_val_q;
  logic              norm_sign_q;
  logic [EXP_W-1:0]  norm_exp_q;
  logic [MANT_W-1:0] norm_mant_q;

  // ALIGN-stage combinational values.
  bf16_unp_t         acc_u, op_u;
  logic              acc_big;
  logic [EXP_W-1:0]  exp_diff;
  logic [3:0]        shamt_d;
  logic              special_d;
  logic [15:0]       special_val_d;

  // ADD-stage combinational values.
  logic              sum_sign, sum_zero;
  logic [EXP_W-1:0]  sum_exp;
  logic [MANT_W:0]   sum_raw;
  logic [EXP_W:0]    exp_inc;
  logic              overflow;

  assign accept = in_valid && in_ready;

  always_comb begin
    acc_u    = bf16_unpack(acc_q);
    op_u     = bf16_unpack(op_q);
    acc_big  = (acc_u.exp >= op_u.exp);
    exp_diff = acc_big ? (acc_u.exp - op_u.exp) : (op_u.exp - acc_u.exp);
    if (acc_u.zero || op_u.zero)
      shamt_d = 4'd0;
    else if (exp_diff > 8'd11)
      shamt_d = 4'd11;
    else
      shamt_d = exp_diff[3:0];

    special_d = acc_u.inf || op_u.inf;
    if (acc_u.inf && op_u.inf && (acc_u.sign != op_u.sign))
      special_val_d = QNAN;
    else if (acc_u.inf)
      special_val_d = {acc_u.sign, EXP_MAX, {FRAC_W{1'b0}}};
    else
      special_val_d = {op_u.sign, EXP_MAX, {FRAC_W{1'b0}}};
  end

  bf16_align_add u_align_add (
    .big_sign   (big_sign_q),
    .big_exp    (big_exp_q),
    .big_mant   (big_mant_q),
    .small_sign (small_sign_q),
    .small_mant (small_mant_q),
    .shamt      (shamt_q),
    .sum_sign   (sum_sign),
    .sum_exp    (sum_exp),
    .sum_raw    (sum_raw),
    .sum_zero   (sum_zero)
  );

  assign exp_inc  = {1'b0, sum_exp} + 1'b1;
  assign overflow = sum_raw[MANT_W] && (exp_inc >= {1'b0, EXP_MAX});

  // Next state and accumulator update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    commit     = 1'b0;
    commit_val = POS_ZERO;
    case (state_q)
      IDLE:  if (accept) state_d = ALIGN;
      ALIGN: state_d = ADD;
      ADD: begin
        if (special_q) begin
          commit     = 1'b1;
          commit_val = special_val_q;
        end else if (sum_zero) begin
          commit     = 1'b1;
          commit_val = POS_ZERO;
        end else if (overflow) begin
          commit     = 1'b1;
          commit_val = {sum_sign, EXP_MAX, {FRAC_W{1'b0}}};
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (norm_mant_q[MANT_W-1]) begin
          commit     = 1'b1;
          commit_val = {norm_sign_q, norm_exp_q, norm_mant_q[MANT_W-2:3]};
        end else if (norm_exp_q <= 8'd1) begin
          // The next shift would take the exponent to 0: flush to +0.
          commit     = 1'b1;
          commit_val = POS_ZERO;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = POS_ZERO;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      acc_d   = commit_val;
      state_d = last_q ? DONE : IDLE;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= POS_ZERO;
      in_ready  <= 1'b1;
      acc_valid <= 1'b0;
      acc_data  <= POS_ZERO;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      in_ready  <= (state_d == IDLE);
      acc_valid <= (state_d == DONE);
      acc_data  <= (state_d == DONE) ? acc_d : POS_ZERO;
    end
  end

  // NOTE: pipeline registers carry no reset; each is written before it is
  // read in every operand's pass, and the FSM returns to IDLE on reset.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_q   <= in_data;
          last_q <= in_last;
        end
      end
      ALIGN: begin
        if (acc_big) begin
          big_sign_q   <= acc_u.sign;
          big_exp_q    <= acc_u.exp;
          big_mant_q   <= acc_u.mant;
          small_sign_q <= op_u.sign;
          small_mant_q <= op_u.mant;
        end else begin
          big_sign_q   <= op_u.sign;
          big_exp_q    <= op_u.exp;
          big_mant_q   <= op_u.mant;
          small_sign_q <= acc_u.sign;
          small_mant_q <= acc_u.mant;
        end
        shamt_q       <= shamt_d;
        special_q     <= special_d;
        special_val_q <= special_val_d;
      end
      ADD: begin
        norm_sign_q <= sum_sign;
        if (sum_raw[MANT_W]) begin
          norm_exp_q  <= exp_inc[EXP_W-1:0];
          norm_mant_q <= sum_raw[MANT_W:1];
        end else begin
          norm_exp_q  <= sum_exp;
          norm_mant_q <= sum_raw[MANT_W-1:0];
        end
      end
      NORM: begin
        if (!norm_mant_q[MANT_W-1]) begin
          norm_mant_q <= norm_mant_q << 1;
          norm_exp_q  <= norm_exp_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bf16_accumulator.sv
// Self-checking bench for bf16_accumulator: directed cases plus randomized
// sequences compared against a value-level BF16 model of the accumulator.
module tb_bf16_accumulator;
  import bf16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        acc_valid;
  logic        out_ready;
  logic [15:0] acc_data;

  int checks   = 0;
  int failures = 0;

  bf16_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .acc_valid (acc_valid),
    .out_ready (out_ready),
    .acc_data  (acc_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: adds op to acc on real values with significands counted in
  // units of 2^-10 (1.0 = 1024), so the three guard bits below the fraction
  // are kept and everything shifted further is lost. lat is the cycle count
  // from accept to the result being visible (3 when the add stage commits,
  // 4 plus one per normalising left shift otherwise).
  function automatic logic [15:0] model_add(input logic [15:0] acc,
                                            input logic [15:0] op,
                                            output int lat);
    int   ea, eb, ma, mb, diff, total, mag, e;
    logic s;
    ea  = int'(acc[14:7]);
    eb  = int'(op[14:7]);
    lat = 3;
    if (ea == 255 && eb == 255 && acc[15] != op[15]) return 16'h7FC0;
    if (ea == 255) return {acc[15], 8'hFF, 7'h00};
    if (eb == 255) return {op[15], 8'hFF, 7'h00};
    ma   = (ea == 0) ? 0 : (128 + int'(acc[6:0])) * 8;
    mb   = (eb == 0) ? 0 : (128 + int'(op[6:0])) * 8;
    diff = (ea > eb) ? ea - eb : eb - ea;
    if (diff > 11) diff = 11;
    if (ea >= eb) mb = mb >> diff;
    else          ma = ma >> diff;
    total = (acc[15] ? -ma : ma) + (op[15] ? -mb : mb);
    if (total == 0) return 16'h0000;
    s   = (total < 0);
    mag = s ? -total : total;
    e   = (ea > eb) ? ea : eb;
    if (mag >= 2048) begin
      mag = mag >> 1;
      e++;
      if (e >= 255) return {s, 8'hFF, 7'h00};
    end
    lat = 4;
    while (mag < 1024) begin
      mag = mag << 1;
      e--;
      if (e == 0) return 16'h0000;
      lat++;
    end
    return {s, e[7:0], mag[9:3]};
  endfunction

  function automatic logic [15:0] rand_op(input logic [15:0] acc);
    logic [7:0] ex;
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {1'($urandom), 8'h00, 7'($urandom)};
    if (r == 1 && acc[14:7] != 8'h00) return acc ^ 16'h8000;
    ex = 8'(BIAS - 6 + $urandom_range(0, 12));
    return {1'($urandom), ex, 7'($urandom)};
  endfunction

  // Called just after a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [15:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // lat = index of the edge at which acc_valid is first seen high,
  // counting the accept edge as 0.
  task automatic wait_result(output logic [15:0] res, output int lat);
    lat = 1;
    while (acc_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout: acc_valid=%b expected 1 within 40 cycles", acc_valid);
    end
    res = acc_data;
  endtask

  task automatic do_seq(input logic [15:0] ops[$], output logic [15:0] res, output int lat);
    foreach (ops[i]) send(ops[i], i == ops.size() - 1);
    wait_result(res, lat);
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2 rst_n  = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_acc_valid: got %b expected 0", acc_valid);
    end
    checks++;
    if (acc_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_acc_data: got %h expected 0000", acc_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] a   [6] = '{16'h3F80, 16'h4040, 16'h3F80, 16'h3F80, 16'h7F7F, 16'h7F80};
    logic [15:0] b   [6] = '{16'h4000, 16'hC000, 16'hBF80, 16'h3B00, 16'h7F7F, 16'hFF80};
    logic [15:0] exp [6] = '{16'h4040, 16'h3F80, 16'h0000, 16'h3F80, 16'h7F80, 16'h7FC0};
    int          elat[6] = '{4, 5, 3, 4, 3, 3};
    logic [15:0] q[$];
    logic [15:0] res;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      q.delete();
      q.push_back(a[i]);
      q.push_back(b[i]);
      do_seq(q, res, lat);
      checks++;
      if (res !== exp[i]) begin
        failures++;
        $display("FAIL directed_value[%0d] %h+%h: got %h expected %h", i, a[i], b[i], res, exp[i]);
      end
      checks++;
      if (lat != elat[i]) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, elat[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_hold_done();
    logic [15:0] q[$];
    logic [15:0] res;
    int          lat;
    out_ready = 1'b0;
    q.push_back(16'h3F80);
    q.push_back(16'h4000);
    do_seq(q, res, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({acc_valid, in_ready, acc_data} !== {1'b1, 1'b0, 16'h4040}) begin
        failures++;
        $display("FAIL hold_done[%0d]: valid=%b ready=%b data=%h expected valid=1 ready=0 data=4040",
                 i, acc_valid, in_ready, acc_data);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({acc_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL release_done: valid=%b ready=%b expected valid=0 ready=1", acc_valid, in_ready);
    end
    q.delete();
    q.push_back(16'h4000);
    do_seq(q, res, lat);
    checks++;
    if (res !== 16'h4000) begin
      failures++;
      $display("FAIL after_clear: got %h expected 4000", res);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] q[$];
    logic [15:0] res;
    int          lat;
    send(16'h4040, 1'b0);
    send(16'hC000, 1'b1);
    @(negedge clk);
    @(negedge clk);     // the second operand is now normalising
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid: valid=%b ready=%b expected valid=0 ready=1", acc_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(16'h3F80);
    do_seq(q, res, lat);
    checks++;
    if (res !== 16'h3F80) begin
      failures++;
      $display("FAIL after_reset_mid: got %h expected 3f80", res);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] res, op, macc;
    int          lat, mlat, n;
    out_ready = 1'b1;
    for (int s = 0; s < 40; s++) begin
      n    = $urandom_range(1, 6);
      macc = 16'h0000;
      mlat = 0;
      for (int k = 0; k < n; k++) begin
        op   = rand_op(macc);
        macc = model_add(macc, op, mlat);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send(op, k == n - 1);
      end
      wait_result(res, lat);
      checks++;
      if (res !== macc) begin
        failures++;
        $display("FAIL random_value[%0d]: got %h expected %h", s, res, macc);
      end
      checks++;
      if (lat != mlat) begin
        failures++;
        $display("FAIL random_latency[%0d]: got %0d expected %0d", s, lat, mlat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
